// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Brief    : Flag indices, op codes, condition codes and status reset value
//            shared by the ALU result stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int FLG_S = 4;
    localparam int FLG_Z = 3;
    localparam int FLG_V = 2;
    localparam int FLG_P = 1;
    localparam int FLG_C = 0;

    localparam int FLAGS_W = 5;
    localparam int OP_W    = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01
    } op_e;

    typedef enum logic [2:0] {
        COND_EQ = 3'd0,
        COND_NE = 3'd1,
        COND_CS = 3'd2,
        COND_CC = 3'd3,
        COND_MI = 3'd4,
        COND_PL = 3'd5,
        COND_VS = 3'd6,
        COND_VC = 3'd7
    } cond_e;

    localparam logic [FLAGS_W-1:0] STATUS_RST = 5'b01000;

    function automatic logic cond_eval(input logic [2:0] sel, input logic [FLAGS_W-1:0] st);
        logic r;
        r = 1'b0;
        case (cond_e'(sel))
            COND_EQ: r =  st[FLG_Z];
            COND_NE: r = ~st[FLG_Z];
            COND_CS: r =  st[FLG_C];
            COND_CC: r = ~st[FLG_C];
            COND_MI: r =  st[FLG_S];
            COND_PL: r = ~st[FLG_S];
            COND_VS: r =  st[FLG_V];
            COND_VC: r = ~st[FLG_V];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_skid_buffer.sv
// ============================================================================
// Module   : alu_skid_buffer
// Brief    : Two-entry valid/ready skid buffer; head in main register, overflow
//            in skid register. in_ready is the inverse of the skid-valid flop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_skid_buffer #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              main_vld_q, main_vld_d;
    logic              skid_vld_q, skid_vld_d;
    logic              w_accept;
    logic              w_drain;

    assign w_accept = in_valid & ~skid_vld_q;
    assign w_drain  = main_vld_q & out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        if (skid_vld_q) begin
            // Full: no accept possible, a drain promotes the skid entry to head.
            if (w_drain) begin
                main_d     = skid_q;
                skid_vld_d = 1'b0;
            end
        end else if (main_vld_q) begin
            if (w_drain && w_accept) begin
                main_d = in_data;
            end else if (w_drain) begin
                main_vld_d = 1'b0;
            end else if (w_accept) begin
                skid_d     = in_data;
                skid_vld_d = 1'b1;
            end
        end else if (w_accept) begin
            main_d     = in_data;
            main_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign in_ready  = ~skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

endmodule

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module   : alu_result_stage
// Brief    : Registered result/status stage after the add/sub units: skid
//            buffering, status register, branch-condition decode and transfer
//            counter. Optional macro ALU_STICKY_OVF_EN adds a sticky overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [WIDTH-1:0]   in_y,
    input  logic [FLAGS_W-1:0] in_flags,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic [WIDTH-1:0]   out_y,
    output logic [FLAGS_W-1:0] out_flags,
    output logic [FLAGS_W-1:0] status,
    input  logic [2:0]         cond_sel,
    output logic               cond_true,
`ifdef ALU_STICKY_OVF_EN
    input  logic               sticky_clr,
    output logic               sticky_ovf,
`endif
    output logic [CNT_W-1:0]   xfer_count
);

    localparam int PAYLOAD_W = OP_W + WIDTH + FLAGS_W;

    logic [PAYLOAD_W-1:0] w_in_payload;
    logic [PAYLOAD_W-1:0] w_out_payload;
    logic                 w_drain;
    logic [FLAGS_W-1:0]   status_q, status_d;
    logic [CNT_W-1:0]     xfer_count_q, xfer_count_d;

    assign w_in_payload = {in_op, in_y, in_flags};

    alu_skid_buffer #(
        .DATA_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {out_op, out_y, out_flags} = w_out_payload;
    assign w_drain = out_valid & out_ready;

    // Architectural status follows completed transfers, not accepted ones.
    always_comb begin
        status_d     = status_q;
        xfer_count_d = xfer_count_q;
        if (w_drain) begin
            status_d     = out_flags;
            xfer_count_d = xfer_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q     <= STATUS_RST;
            xfer_count_q <= '0;
        end else begin
            status_q     <= status_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign status     = status_q;
    assign xfer_count = xfer_count_q;
    assign cond_true  = cond_eval(cond_sel, status_q);

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) begin
            sticky_d = 1'b0;
        end
        if (w_drain && out_flags[FLG_V]) begin
            sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module   : tb_alu_result_stage
// Brief    : Directed self-checking bench for alu_result_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_y;
    logic [4:0] in_flags;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [3:0] out_y;
    logic [4:0] out_flags;
    logic [4:0] status;
    logic [2:0] cond_sel;
    logic       cond_true;
    logic [7:0] xfer_count;
`ifdef ALU_STICKY_OVF_EN
    logic       sticky_clr;
    logic       sticky_ovf;
`endif

    int errors = 0;
    int checks = 0;

    alu_result_stage #(
        .WIDTH (4),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_y       (in_y),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_y      (out_y),
        .out_flags  (out_flags),
        .status     (status),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true),
`ifdef ALU_STICKY_OVF_EN
        .sticky_clr (sticky_clr),
        .sticky_ovf (sticky_ovf),
`endif
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] y, input logic [4:0] f);
        in_valid = v;
        in_op    = op;
        in_y     = y;
        in_flags = f;
    endtask

    task automatic cond(input logic [2:0] sel, input logic exp, input string tag);
        cond_sel = sel;
        #1;
        check(tag, 32'(cond_true), 32'(exp));
    endtask

    initial begin
        logic [8:0] v;
        rst       = 1'b1;
        out_ready = 1'b0;
        cond_sel  = 3'd0;
        drive(1'b0, 2'b00, 4'h0, 5'b00000);
`ifdef ALU_STICKY_OVF_EN
        sticky_clr = 1'b0;
`endif
        tick;
        tick;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_status",    32'(status),    32'h08);
        check("rst_xfer",      32'(xfer_count), 32'd0);
        check("rst_out_y",     32'(out_y),     32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_cond_eq",   32'(cond_true), 32'd1);
`ifdef ALU_STICKY_OVF_EN
        check("rst_sticky",    32'(sticky_ovf), 32'd0);
`endif
        rst = 1'b0;

        // Single ADD item, one-cycle latency then drain.
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 4'h9, 5'b10100);
        tick;
        check("a_out_valid", 32'(out_valid), 32'd1);
        check("a_out_y",     32'(out_y),     32'h9);
        check("a_out_flags", 32'(out_flags), 32'h14);
        check("a_status_pre", 32'(status),   32'h08);
        in_valid = 1'b0;
        tick;
        check("a_out_valid_after", 32'(out_valid), 32'd0);
        check("a_status", 32'(status),     32'h14);
        check("a_xfer",   32'(xfer_count), 32'd1);
        cond(3'd4, 1'b1, "a_cond_mi");
        cond(3'd6, 1'b1, "a_cond_vs");
        cond(3'd0, 1'b0, "a_cond_eq");

        // Back-pressure: third item must not be accepted.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 4'h1, 5'b00000);
        tick;
        check("b1_in_ready", 32'(in_ready), 32'd1);
        check("b1_out_y",    32'(out_y),    32'h1);
        drive(1'b1, 2'b01, 4'h2, 5'b00001);
        tick;
        check("b2_in_ready", 32'(in_ready), 32'd0);
        check("b2_out_y",    32'(out_y),    32'h1);
        drive(1'b1, 2'b00, 4'h3, 5'b00010);
        tick;
        check("b3_in_ready", 32'(in_ready), 32'd0);
        check("b3_out_y",    32'(out_y),    32'h1);
        check("b3_out_op",   32'(out_op),   32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick;
        check("b4_out_y",    32'(out_y),     32'h2);
        check("b4_out_op",   32'(out_op),    32'd1);
        check("b4_in_ready", 32'(in_ready),  32'd1);
        check("b4_status",   32'(status),    32'h00);
        check("b4_xfer",     32'(xfer_count), 32'd2);
        tick;
        check("b5_out_valid", 32'(out_valid), 32'd0);
        check("b5_status",    32'(status),    32'h01);
        check("b5_xfer",      32'(xfer_count), 32'd3);

        // SUB with zero result: Z and C (borrow) set.
        drive(1'b1, 2'b01, 4'h0, 5'b01001);
        tick;
        check("c_out_valid", 32'(out_valid), 32'd1);
        check("c_out_y",     32'(out_y),     32'h0);
        in_valid = 1'b0;
        tick;
        check("c_status", 32'(status),     32'h09);
        check("c_xfer",   32'(xfer_count), 32'd4);
        cond(3'd0, 1'b1, "c_cond_eq");
        cond(3'd1, 1'b0, "c_cond_ne");
        cond(3'd2, 1'b1, "c_cond_cs");
        cond(3'd3, 1'b0, "c_cond_cc");

        // Fill both entries, then asynchronous reset mid-cycle.
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 4'h5, 5'b00100);
        tick;
        drive(1'b1, 2'b00, 4'h6, 5'b10000);
        tick;
        check("r_full_in_ready",  32'(in_ready),  32'd0);
        check("r_full_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("r_out_valid", 32'(out_valid),  32'd0);
        check("r_in_ready",  32'(in_ready),   32'd1);
        check("r_status",    32'(status),     32'h08);
        check("r_xfer",      32'(xfer_count), 32'd0);
        tick;
        rst = 1'b0;

        // Full-rate streaming of 300 items; counter wraps.
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            v = 9'(i);
            drive(1'b1, {1'b0, v[0]}, v[3:0], v[4:0]);
            tick;
            check("s_out_y",     32'(out_y),     32'(v[3:0]));
            check("s_out_flags", 32'(out_flags), 32'(v[4:0]));
            check("s_in_ready",  32'(in_ready),  32'd1);
        end
        check("s_xfer_mid", 32'(xfer_count), 32'd43);
        in_valid = 1'b0;
        tick;
        check("s_xfer_wrap",  32'(xfer_count), 32'd44);
        check("s_out_valid",  32'(out_valid),  32'd0);
        check("s_status",     32'(status),     32'h0B);

`ifdef ALU_STICKY_OVF_EN
        drive(1'b1, 2'b00, 4'h7, 5'b00100);
        tick;
        in_valid = 1'b0;
        tick;
        check("k_set", 32'(sticky_ovf), 32'd1);
        drive(1'b1, 2'b00, 4'h1, 5'b00000);
        tick;
        in_valid = 1'b0;
        tick;
        check("k_hold", 32'(sticky_ovf), 32'd1);
        drive(1'b1, 2'b00, 4'h8, 5'b00100);
        tick;
        in_valid   = 1'b0;
        sticky_clr = 1'b1;
        tick;
        check("k_set_wins", 32'(sticky_ovf), 32'd1);
        tick;
        check("k_clear", 32'(sticky_ovf), 32'd0);
        sticky_clr = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
